clock_period_meter: RTL and testbench

//  Measures a slow, asynchronous square wave (e.g. a divided tick such as the 1 Hz/2 Hz

---
 rtl/clock_meter_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/clock_period_meter.sv | 117 +++++++++++
 tb/tb_clock_period_meter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter and its front end.
package clock_meter_pkg;

   localparam int CNT_W_DEF       = 32;
   localparam int TIMEOUT_DEF     = 50000000;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RISE,
      MEASURE
   } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input into the clk domain and flags its edges.
// Both edges see the same SYNC_STAGES+1 cycle latency, so pulse widths are preserved.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_levelDly;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync     <= '0;
         r_levelDly <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_levelDly <= r_sync[SYNC_STAGES-1];
      end
   end

   assign level = r_sync[SYNC_STAGES-1];
   assign rise  = level & ~r_levelDly;
   assign fall  = ~level & r_levelDly;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with a one-cycle valid strobe and a sticky timeout for a stalled input.
module clock_period_meter
   import clock_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             busy,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   meter_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hiCap;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_highTime;
   logic             r_valid;
   logic             r_busy;
   logic             r_timeout;
   logic             w_rise;
   logic             w_fall;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_syncEdge (
      .clk     (clk),
      .rst     (rst),
      .async_in(sig_in),
      .level   (),
      .rise    (w_rise),
      .fall    (w_fall)
   );

   // A rise restarts the count at 1, so the count seen at the next rise is the period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_hiCap    <= '0;
         r_period   <= '0;
         r_highTime <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!enable) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt   <= '0;
                  r_state <= WAIT_RISE;
                  r_busy  <= 1'b1;
               end
               WAIT_RISE: begin
                  if (w_rise) begin
                     r_state <= MEASURE;
                     r_cnt   <= ONE_C;
                     r_hiCap <= '0;
                  end else if (r_cnt == TIMEOUT_C) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                  end else begin
                     r_cnt <= r_cnt + ONE_C;
                  end
               end
               MEASURE: begin
                  if (w_fall) begin
                     r_hiCap <= r_cnt;
                  end
                  // A rise landing on the timeout count is still a legal period.
                  if (w_rise) begin
                     r_period   <= r_cnt;
                     r_highTime <= r_hiCap;
                     r_valid    <= 1'b1;
                     r_timeout  <= 1'b0;
                     r_cnt      <= ONE_C;
                  end else if (r_cnt == TIMEOUT_C) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= WAIT_RISE;
                  end else begin
                     r_cnt <= r_cnt + ONE_C;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign period    = r_period;
   assign high_time = r_highTime;
   assign valid     = r_valid;
   assign busy      = r_busy;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: two instances (TIMEOUT 20 and 10) share
// one stimulus stream; the second one exercises a rise landing on the timeout count.
module tb_clock_period_meter;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        sig_in;
   logic [31:0] period;
   logic [31:0] high_time;
   logic        valid;
   logic        busy;
   logic        timeout;
   logic [31:0] period2;
   logic [31:0] high_time2;
   logic        valid2;
   logic        busy2;
   logic        timeout2;

   int testsRun;
   int testsFailed;

   int stepNum;
   int validCnt;
   int firstValidStep;
   int lastValidStep;
   int gapsOk;
   int busyAllHigh;
   int timeoutAtValid;
   int lastPeriod;
   int lastHigh;
   int firstTimeoutStep;
   int validCnt2;
   int lastPeriod2;
   int timeoutAtValid2;
   int firstTimeoutStep2;

   clock_period_meter #(
      .CNT_W(32), .TIMEOUT(20), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
      .period(period), .high_time(high_time), .valid(valid),
      .busy(busy), .timeout(timeout)
   );

   clock_period_meter #(
      .CNT_W(32), .TIMEOUT(10), .SYNC_STAGES(2)
   ) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
      .period(period2), .high_time(high_time2), .valid(valid2),
      .busy(busy2), .timeout(timeout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=time_limit expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic clearStats();
      stepNum = 0; validCnt = 0; firstValidStep = 0; lastValidStep = 0;
      gapsOk = 1; busyAllHigh = 1; timeoutAtValid = 0; lastPeriod = -1;
      lastHigh = -1; firstTimeoutStep = 0; validCnt2 = 0; lastPeriod2 = -1;
      timeoutAtValid2 = 0; firstTimeoutStep2 = 0;
   endtask

   // Drive one clk cycle of sig_in, then sample both DUTs 1 time unit after the edge.
   task automatic stepCycle(input logic level);
      sig_in = level;
      @(posedge clk);
      #1;
      stepNum++;
      if (busy !== 1'b1) busyAllHigh = 0;
      if (timeout === 1'b1 && firstTimeoutStep == 0) firstTimeoutStep = stepNum;
      if (timeout2 === 1'b1 && firstTimeoutStep2 == 0) firstTimeoutStep2 = stepNum;
      if (valid === 1'b1) begin
         validCnt++;
         if (firstValidStep == 0) firstValidStep = stepNum;
         if (lastValidStep != 0 && stepNum - lastValidStep != 10) gapsOk = 0;
         lastValidStep = stepNum;
         lastPeriod = int'(period);
         lastHigh = int'(high_time);
         if (timeout === 1'b1) timeoutAtValid = 1;
      end
      if (valid2 === 1'b1) begin
         validCnt2++;
         lastPeriod2 = int'(period2);
         if (timeout2 === 1'b1) timeoutAtValid2 = 1;
      end
   endtask

   task automatic applyStimulus(input int hi, input int lo, input int nPeriods);
      for (int p = 0; p < nPeriods; p++) begin
         for (int c = 0; c < hi + lo; c++) begin
            stepCycle(c < hi);
         end
      end
   endtask

   // Mimics the clock divider: reload with startCnt, toggle when it reaches 0.
   task automatic applyDivider(input int startCnt, input int nPeriods);
      logic level;
      int   divCnt;
      level = 1'b1;
      divCnt = startCnt;
      for (int i = 0; i < 2 * (startCnt + 1) * nPeriods; i++) begin
         stepCycle(level);
         if (divCnt == 0) begin
            level = ~level;
            divCnt = startCnt;
         end else begin
            divCnt--;
         end
      end
   endtask

   initial begin
      testsRun = 0;
      testsFailed = 0;
      clearStats();
      rst = 1'b1;
      enable = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_period", period, 32'd0);
      checkOutput("reset_high_time", high_time, 32'd0);
      checkOutput("reset_valid", {31'd0, valid}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_timeout", {31'd0, timeout}, 32'd0);
      rst = 1'b0;
      stepCycle(1'b0);
      checkOutput("idle_after_reset_valid", {31'd0, valid}, 32'd0);

      // 5 high / 5 low from IDLE: first valid only after the second synchronized rise.
      enable = 1'b1;
      clearStats();
      applyStimulus(5, 5, 6);
      checkOutput("h5l5_valid_count", validCnt, 32'd5);
      checkOutput("h5l5_first_valid_step", firstValidStep, 32'd13);
      checkOutput("h5l5_valid_spacing", gapsOk, 32'd1);
      checkOutput("h5l5_period", lastPeriod, 32'd10);
      checkOutput("h5l5_high_time", lastHigh, 32'd5);
      checkOutput("h5l5_busy", busyAllHigh, 32'd1);
      checkOutput("h5l5_timeout_at_valid", timeoutAtValid, 32'd0);
      checkOutput("rise_at_timeout_valid_count", validCnt2, 32'd5);
      checkOutput("rise_at_timeout_period", lastPeriod2, 32'd10);
      checkOutput("rise_at_timeout_timeout", timeoutAtValid2, 32'd0);

      clearStats();
      applyStimulus(3, 7, 3);
      checkOutput("h3l7_valid_count", validCnt, 32'd3);
      checkOutput("h3l7_first_valid_step", firstValidStep, 32'd3);
      checkOutput("h3l7_period", lastPeriod, 32'd10);
      checkOutput("h3l7_high_time", lastHigh, 32'd3);

      clearStats();
      applyDivider(4, 3);
      checkOutput("divider_valid_count", validCnt, 32'd3);
      checkOutput("divider_period", lastPeriod, 32'd10);
      checkOutput("divider_high_time", lastHigh, 32'd5);

      // Dropping enable returns to IDLE while the last measurement is held.
      enable = 1'b0;
      stepCycle(1'b0);
      checkOutput("disable_busy", {31'd0, busy}, 32'd0);
      checkOutput("disable_valid", {31'd0, valid}, 32'd0);
      repeat (3) stepCycle(1'b0);
      checkOutput("disable_period_hold", period, 32'd10);
      checkOutput("disable_high_hold", high_time, 32'd5);
      enable = 1'b1;
      clearStats();
      applyStimulus(5, 5, 3);
      checkOutput("reenable_first_valid_step", firstValidStep, 32'd13);
      checkOutput("reenable_valid_count", validCnt, 32'd2);

      // Stuck-low input: TIMEOUT=20 fires after 22 sampled edges, TIMEOUT=10 after 12.
      enable = 1'b0;
      repeat (2) stepCycle(1'b0);
      enable = 1'b1;
      clearStats();
      repeat (60) stepCycle(1'b0);
      checkOutput("stuck_timeout_step", firstTimeoutStep, 32'd22);
      checkOutput("stuck_timeout_step_t10", firstTimeoutStep2, 32'd12);
      checkOutput("stuck_no_valid", validCnt, 32'd0);
      checkOutput("stuck_busy", busyAllHigh, 32'd1);
      checkOutput("stuck_timeout_sticky", {31'd0, timeout}, 32'd1);
      clearStats();
      applyStimulus(5, 5, 1);
      checkOutput("restart_first_rise_no_valid", validCnt, 32'd0);
      checkOutput("restart_timeout_still_set", {31'd0, timeout}, 32'd1);
      clearStats();
      applyStimulus(5, 5, 2);
      checkOutput("restart_valid_count", validCnt, 32'd2);
      checkOutput("restart_timeout_cleared", {31'd0, timeout}, 32'd0);
      checkOutput("restart_period", lastPeriod, 32'd10);

      // Asynchronous reset mid-cycle clears outputs before the next clock edge.
      applyStimulus(5, 5, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_period", period, 32'd0);
      checkOutput("async_rst_high_time", high_time, 32'd0);
      checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_rst_period_t10", period2, 32'd0);
      #1;
      rst = 1'b0;
      checkOutput("after_rst_idle_busy", {31'd0, busy}, 32'd0);
      stepCycle(1'b0);
      checkOutput("after_rst_wait_rise_busy", {31'd0, busy}, 32'd1);
      checkOutput("after_rst_valid", {31'd0, valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
